freq_gate_ctrl: RTL and testbench
=================================

Name: freq_gate_ctrl

Overview:
Sequencer for the BCD frequency-counter datapath. It generates the one-cycle gate strobe that clears the BCD counter chain and latches its previous count into the result register. It selects the gate length (1 s / 100 ms / 10 ms), and suppresses the first, invalid capture after (re)start. It tracks overflow of the top BCD digit and presents each measurement to a display/readout consumer over a valid/ack handshake.

Parameters:
CLK_HZ, 50000000, CLOCK_50 frequency in Hz; gate length N = CLK_HZ / 10^range. Must be divisible by 100; sim uses 1000.
TW, 26, gate-timer width; must satisfy 2^TW > CLK_HZ.

Ports:
CLOCK_50  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request for a single measurement (honoured in IDLE only)
cont  input  1  continuous mode: re-arm after every capture while high
range_sel  input  2  0 = 1 s, 1 = 100 ms, 2 = 10 ms, 3 = reserved (treated as 0)
ovf_in  input  1  carry out of the top BCD digit
meas_ack  input  1  consumer has taken the current measurement
gate_strobe  output  1  one-cycle pulse to the datapath (clear counters + latch result)
busy  output  1  high in every state except IDLE
meas_valid  output  1  result register holds a valid, unconsumed measurement
meas_range  output  2  range used for the measurement flagged by meas_valid
meas_ovf  output  1  overflow occurred during that measurement's gate
meas_missed  output  1  sticky: a valid measurement was overwritten before ack

Behaviour:
- All state and outputs update on posedge CLOCK_50. Reset is sampled synchronously; reset==0 forces IDLE, with every output 0 and the timer 0.
- States:
  - IDLE: entered from reset, or after a capture when cont==0.
  - ALIGN: one cycle. gate_strobe=1; range_sel is latched into an internal gate-range register; the timer loads N-1; the sticky overflow flag clears. This capture is a discard and never raises meas_valid.
  - GATE: the timer decrements each cycle. At timer==0: gate_strobe=1 (capture), then go to ALIGN_NEXT handling (below).
- Transitions:
  - IDLE -> ALIGN when start==1 or cont==1.
  - GATE at timer==0:
    - capture is issued;
    - if cont==1 and range_sel equals the latched range: reload the timer with N-1, clear the ovf flag, stay in GATE. Back-to-back gates therefore share one strobe, and strobes are exactly N cycles apart.
    - if cont==1 and range differs: go to ALIGN next cycle.
    - otherwise: go to IDLE.
- Latency: start high in IDLE at cycle t -> strobe at t+1 -> capture strobe at t+1+N. meas_valid rises at t+2+N, aligned with the result-register update.
- Capture effects (the cycle after a capture strobe):
  - meas_valid=1, meas_range=latched range;
  - meas_ovf = sticky ovf flag, including ovf_in during the capture cycle itself.
- Overflow: the sticky flag sets on any cycle in GATE where ovf_in==1.
- Handshake:
  - meas_valid holds until a cycle with meas_ack==1, then clears.
  - Ack coinciding with a new capture: valid stays 1 for the new data; meas_missed is unchanged.
  - New capture while valid==1 and no ack: data is overwritten and meas_missed sets. meas_missed clears only on reset or on a start pulse.
  - meas_ack while meas_valid==0 is ignored.
- Range change mid-gate: range_sel is ignored until the gate end. It then forces a realign in continuous mode, so no gate ever mixes two ranges.
- cont dropping mid-gate: the current gate completes and is captured, then IDLE.
- start outside IDLE: ignored.
- range_sel==3: behaves as 0 everywhere, and meas_range reports 0.
- Reset mid-gate: immediate IDLE, with no strobe and no valid.

Decomposition:
- Shared package freq_meter_pkg holds:
  - the state encoding (IDLE, ALIGN, GATE);
  - range code constants (RANGE_1S=0, RANGE_100MS=1, RANGE_10MS=2);
  - a constant function gate_len(clk_hz, range) returning N.
- One sub-module, gate_timer: loadable TW-bit down-counter with load, enable, and a zero flag. The FSM, flags and handshake stay in freq_gate_ctrl.

Test Plan (CLK_HZ=1000, so N = 1000 / 100 / 10):
1. Reset low for 3 cycles, then start with range 2 at cycle 10 -> strobes at cycles 11 and 21; meas_valid=1 from cycle 22; meas_range=2; busy 0 from cycle 22.
2. cont=1, range=1, ack every valid -> strobes every 100 cycles after the first; meas_valid rises 1 cycle after each capture strobe except the first; meas_missed stays 0.
3. cont=1, range=2, never ack -> second capture sets meas_missed=1 while meas_valid stays 1. Then ack -> meas_valid=0 next cycle; meas_missed persists until start.
4. cont=1, range_sel 2 -> 1 at mid-gate -> the current gate still lasts 10 cycles. An ALIGN strobe follows one cycle after capture, then the next capture comes 100 cycles later with meas_range=1.
5. ovf_in pulsed for 1 cycle in gate 1 only -> meas_ovf=1 for gate 1 and 0 for gate 2. Pulsing ovf_in on the capture cycle itself -> meas_ovf=1.
6. Reset asserted 5 cycles into a gate -> next cycle: IDLE, busy=0, meas_valid=0, no further gate_strobe. range_sel=3 single run -> 1000-cycle gate, meas_range=0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the BCD frequency-meter control path.
//   - FSM state encoding used by freq_gate_ctrl
//   - range codes for the gate length selector
//   - gate_len(): gate length in clock cycles for a given range
//   - norm_range(): maps the reserved range code onto the 1 s range
package freq_meter_pkg;

   // FSM state encoding
   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StAlign = 2'd1;
   localparam logic [1:0] StGate  = 2'd2;

   // Gate range codes
   localparam logic [1:0] RANGE_1S    = 2'd0;
   localparam logic [1:0] RANGE_100MS = 2'd1;
   localparam logic [1:0] RANGE_10MS  = 2'd2;

   // Gate length in clock cycles: clk_hz / 10^range (reserved code -> 1 s)
   function automatic int unsigned gate_len(input int unsigned clk_hz, input logic [1:0] range);
      int unsigned len;
      unique case (range)
         RANGE_100MS: len = clk_hz / 10;
         RANGE_10MS:  len = clk_hz / 100;
         default:     len = clk_hz;
      endcase
      return len;
   endfunction

   // Reserved code 3 behaves as the 1 s range everywhere, including reporting
   function automatic logic [1:0] norm_range(input logic [1:0] range);
      return (range == 2'd3) ? RANGE_1S : range;
   endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter that times one measurement gate.
// Ports:
//   clk      - clock
//   reset    - synchronous active-low reset (clears the count)
//   load     - load load_val (takes priority over en)
//   en       - decrement by one per cycle, saturating at zero
//   load_val - value loaded when load is high
//   zero     - count is zero
module gate_timer #(
   parameter int unsigned TW = 26
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          en,
   input  logic [TW-1:0] load_val,
   output logic          zero
);

   logic [TW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate sequencer for the BCD frequency counter. Issues the one-cycle gate
// strobe (clear counters + latch result), times the gate, drops the first
// capture after (re)start, tracks top-digit overflow and hands each result to
// the readout over a valid/ack handshake.
// Ports:
//   CLOCK_50    - system clock
//   reset       - synchronous active-low reset
//   start       - single-measurement request (IDLE only)
//   cont        - continuous mode, re-arm after each capture while high
//   range_sel   - 0 = 1 s, 1 = 100 ms, 2 = 10 ms, 3 = treated as 0
//   ovf_in      - carry out of the top BCD digit
//   meas_ack    - readout has taken the current measurement
//   gate_strobe - one-cycle strobe to the datapath
//   busy        - not IDLE
//   meas_valid  - unconsumed valid measurement present
//   meas_range  - range of the flagged measurement
//   meas_ovf    - overflow seen during that measurement's gate
//   meas_missed - sticky: a valid measurement was overwritten before ack
module freq_gate_ctrl
   import freq_meter_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned TW     = 26
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic       cont,
   input  logic [1:0] range_sel,
   input  logic       ovf_in,
   input  logic       meas_ack,
   output logic       gate_strobe,
   output logic       busy,
   output logic       meas_valid,
   output logic [1:0] meas_range,
   output logic       meas_ovf,
   output logic       meas_missed
);

   localparam logic [TW-1:0] Len1sM1    = TW'(gate_len(CLK_HZ, RANGE_1S) - 1);
   localparam logic [TW-1:0] Len100msM1 = TW'(gate_len(CLK_HZ, RANGE_100MS) - 1);
   localparam logic [TW-1:0] Len10msM1  = TW'(gate_len(CLK_HZ, RANGE_10MS) - 1);

   function automatic logic [TW-1:0] len_m1(input logic [1:0] range);
      logic [TW-1:0] v;
      unique case (range)
         RANGE_100MS: v = Len100msM1;
         RANGE_10MS:  v = Len10msM1;
         default:     v = Len1sM1;
      endcase
      return v;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [1:0]    range_q, range_d;
   logic          ovf_q, ovf_d;
   logic          valid_q, valid_d;
   logic [1:0]    mrange_q, mrange_d;
   logic          movf_q, movf_d;
   logic          missed_q, missed_d;

   logic          timer_load;
   logic          timer_en;
   logic [TW-1:0] timer_val;
   logic          timer_zero;
   logic [1:0]    sel_range;
   logic          capture;

   assign sel_range = norm_range(range_sel);
   assign capture   = (state_q == StGate) && timer_zero;

   gate_timer #(
      .TW(TW)
   ) u_gate_timer (
      .clk      (CLOCK_50),
      .reset    (reset),
      .load     (timer_load),
      .en       (timer_en),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   // Sequencer: range latching, timer control and sticky overflow
   always_comb begin
      state_d    = state_q;
      range_d    = range_q;
      ovf_d      = ovf_q;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      timer_val  = len_m1(range_q);
      unique case (state_q)
         StIdle: begin
            if (start || cont) begin
               state_d = StAlign;
            end
         end
         StAlign: begin
            // Discard strobe: starts the first real gate with a fresh range
            range_d    = sel_range;
            timer_load = 1'b1;
            timer_val  = len_m1(sel_range);
            ovf_d      = 1'b0;
            state_d    = StGate;
         end
         StGate: begin
            timer_en = 1'b1;
            if (ovf_in) begin
               ovf_d = 1'b1;
            end
            if (timer_zero) begin
               if (cont && (sel_range == range_q)) begin
                  // Back-to-back gate: this capture strobe also opens the next gate
                  timer_load = 1'b1;
                  ovf_d      = 1'b0;
               end else if (cont) begin
                  state_d = StAlign;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Result handshake toward the readout
   always_comb begin
      valid_d  = valid_q;
      mrange_d = mrange_q;
      movf_d   = movf_q;
      missed_d = missed_q;
      if (meas_ack && valid_q) begin
         valid_d = 1'b0;
      end
      if (capture) begin
         valid_d  = 1'b1;
         mrange_d = range_q;
         movf_d   = ovf_q | ovf_in;
         if (valid_q && !meas_ack) begin
            missed_d = 1'b1;
         end
      end
      if ((state_q == StIdle) && start) begin
         missed_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q  <= StIdle;
         range_q  <= RANGE_1S;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         mrange_q <= 2'd0;
         movf_q   <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         range_q  <= range_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         mrange_q <= mrange_d;
         movf_q   <= movf_d;
         missed_q <= missed_d;
      end
   end

   assign gate_strobe = (state_q == StAlign) || capture;
   assign busy        = (state_q != StIdle);
   assign meas_valid  = valid_q;
   assign meas_range  = mrange_q;
   assign meas_ovf    = movf_q;
   assign meas_missed = missed_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl at CLK_HZ=1000 (gates of 1000/100/10 cycles).
module tb_freq_gate_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       cont;
   logic [1:0] range_sel;
   logic       ovf_in;
   logic       meas_ack;
   logic       gate_strobe;
   logic       busy;
   logic       meas_valid;
   logic [1:0] meas_range;
   logic       meas_ovf;
   logic       meas_missed;

   int checks = 0;
   int errors = 0;

   freq_gate_ctrl #(
      .CLK_HZ(1000),
      .TW    (11)
   ) dut (
      .CLOCK_50    (clk),
      .reset       (reset),
      .start       (start),
      .cont        (cont),
      .range_sel   (range_sel),
      .ovf_in      (ovf_in),
      .meas_ack    (meas_ack),
      .gate_strobe (gate_strobe),
      .busy        (busy),
      .meas_valid  (meas_valid),
      .meas_range  (meas_range),
      .meas_ovf    (meas_ovf),
      .meas_missed (meas_missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until gate_strobe is seen (bounded); n is the number of ticks taken
   task automatic wait_strobe(input string tag, input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!gate_strobe && (n < max));
      check_val({tag, "_seen"}, gate_strobe, 1);
   endtask

   int n;
   int seen;

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      cont      = 1'b0;
      range_sel = 2'd0;
      ovf_in    = 1'b0;
      meas_ack  = 1'b0;

      // 1. reset state, single 10 ms measurement
      repeat (3) tick();
      check_val("rst_strobe", gate_strobe, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_valid", meas_valid, 0);
      check_val("rst_missed", meas_missed, 0);
      reset = 1'b1;
      repeat (6) tick();
      start = 1'b1; range_sel = 2'd2;
      tick();
      start = 1'b0;
      check_val("t1_align_strobe", gate_strobe, 1);
      check_val("t1_busy", busy, 1);
      wait_strobe("t1_cap", 50, n);
      check_val("t1_gate_len", n, 10);
      tick();
      check_val("t1_valid", meas_valid, 1);
      check_val("t1_range", meas_range, 2);
      check_val("t1_busy_done", busy, 0);
      check_val("t1_ovf", meas_ovf, 0);

      // 2. continuous 100 ms, ack every result
      cont = 1'b1; range_sel = 2'd1; meas_ack = 1'b1;
      tick();
      meas_ack = 1'b0;
      check_val("t2_align_strobe", gate_strobe, 1);
      check_val("t2_no_valid_align", meas_valid, 0);
      wait_strobe("t2_cap0", 300, n);
      check_val("t2_first_len", n, 100);
      for (int g = 0; g < 3; g++) begin
         tick();
         check_val("t2_valid", meas_valid, 1);
         check_val("t2_range", meas_range, 1);
         check_val("t2_missed", meas_missed, 0);
         meas_ack = 1'b1;
         tick();
         meas_ack = 1'b0;
         check_val("t2_acked", meas_valid, 0);
         if (g == 2) cont = 1'b0;
         wait_strobe("t2_cap", 300, n);
         check_val("t2_period", n + 2, 100);
      end
      tick();
      check_val("t2_idle", busy, 0);
      check_val("t2_last_valid", meas_valid, 1);
      meas_ack = 1'b1;
      tick();
      meas_ack = 1'b0;

      // 3. continuous 10 ms, no ack -> missed
      cont = 1'b1; range_sel = 2'd2;
      tick();
      check_val("t3_align_strobe", gate_strobe, 1);
      wait_strobe("t3_cap1", 50, n);
      check_val("t3_len1", n, 10);
      tick();
      check_val("t3_valid1", meas_valid, 1);
      check_val("t3_missed1", meas_missed, 0);
      wait_strobe("t3_cap2", 50, n);
      check_val("t3_len2", n, 9);
      tick();
      check_val("t3_valid2", meas_valid, 1);
      check_val("t3_missed2", meas_missed, 1);
      meas_ack = 1'b1;
      tick();
      meas_ack = 1'b0;
      check_val("t3_ack_clear", meas_valid, 0);
      check_val("t3_missed_sticky", meas_missed, 1);

      // 4. range change mid-gate -> gate finishes, then realign
      range_sel = 2'd1;
      wait_strobe("t4_cap", 50, n);
      check_val("t4_len_unchanged", n, 8);
      tick();
      check_val("t4_realign_strobe", gate_strobe, 1);
      check_val("t4_valid_old", meas_valid, 1);
      check_val("t4_range_old", meas_range, 2);
      meas_ack = 1'b1; cont = 1'b0;
      tick();
      meas_ack = 1'b0;
      check_val("t4_acked", meas_valid, 0);
      wait_strobe("t4_cap_new", 300, n);
      check_val("t4_new_len", n, 99);
      tick();
      check_val("t4_valid_new", meas_valid, 1);
      check_val("t4_range_new", meas_range, 1);
      check_val("t4_idle", busy, 0);
      check_val("t4_missed_kept", meas_missed, 1);

      // 5. overflow tracking, ack coinciding with capture
      start = 1'b1; cont = 1'b1; meas_ack = 1'b1; range_sel = 2'd2;
      tick();
      start = 1'b0; meas_ack = 1'b0;
      check_val("t5_align_strobe", gate_strobe, 1);
      check_val("t5_missed_cleared", meas_missed, 0);
      check_val("t5_valid_acked", meas_valid, 0);
      tick();
      ovf_in = 1'b1;
      tick();
      ovf_in = 1'b0;
      wait_strobe("t5_cap1", 50, n);
      check_val("t5_len1", n, 8);
      tick();
      check_val("t5_ovf1", meas_ovf, 1);
      check_val("t5_valid1", meas_valid, 1);
      wait_strobe("t5_cap2", 50, n);
      check_val("t5_len2", n, 9);
      meas_ack = 1'b1;
      tick();
      meas_ack = 1'b0;
      check_val("t5_valid2", meas_valid, 1);
      check_val("t5_missed2", meas_missed, 0);
      check_val("t5_ovf2", meas_ovf, 0);
      meas_ack = 1'b1;
      tick();
      meas_ack = 1'b0;
      wait_strobe("t5_cap3", 50, n);
      check_val("t5_len3", n, 8);
      ovf_in = 1'b1; cont = 1'b0;
      tick();
      ovf_in = 1'b0;
      check_val("t5_ovf_cap_cycle", meas_ovf, 1);
      check_val("t5_idle", busy, 0);
      check_val("t5_missed3", meas_missed, 0);

      // 6. reset mid-gate, then reserved range as 1 s
      start = 1'b1; range_sel = 2'd3;
      tick();
      start = 1'b0;
      check_val("t6_align_strobe", gate_strobe, 1);
      repeat (5) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_val("t6_rst_busy", busy, 0);
      check_val("t6_rst_valid", meas_valid, 0);
      check_val("t6_rst_strobe", gate_strobe, 0);
      check_val("t6_rst_ovf", meas_ovf, 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gate_strobe) seen++;
      end
      check_val("t6_no_strobe", seen, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("t6_r3_align", gate_strobe, 1);
      wait_strobe("t6_r3_cap", 1100, n);
      check_val("t6_r3_len", n, 1000);
      tick();
      check_val("t6_r3_valid", meas_valid, 1);
      check_val("t6_r3_range", meas_range, 0);
      check_val("t6_r3_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
